// File: rtl/priority_arbiter.sv
// priority_arbiter: WIDTH-way request arbiter with registered grant.
//
// Selection is either fixed priority (highest eligible index wins) or
// round-robin (first eligible index at or above ptr, wrapping). A grant is held
// until ack, then the arbiter re-arbitrates on the same edge, so back-to-back
// grants have no idle cycle.
//
// Optional feature, macro PRIO_ARB_MASK_EN: adds a writable request mask
// (mask_we/mask_din). Without the macro the mask is constant all ones.
//
// Ports:
//   clk          clock, rising edge
//   rst          asynchronous active-high reset
//   req          request vector, bit n = requester n pending
//   mode         0 = fixed priority, 1 = round-robin (sampled when arbitrating)
//   ack          consumer accepts the current grant (ignored when idle)
//   mask_we      (PRIO_ARB_MASK_EN only) load mask_din into the mask register
//   mask_din     (PRIO_ARB_MASK_EN only) new mask value
//   grant_valid  a grant is held
//   grant_idx    index of the granted requester, 0 when no grant
//   grant_onehot one-hot form of grant_idx, 0 when no grant
//   busy         same as grant_valid
module priority_arbiter #(
  parameter int WIDTH = 32,
  parameter int IDX_W = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] req,
  input  logic             mode,
  input  logic             ack,
`ifdef PRIO_ARB_MASK_EN
  input  logic             mask_we,
  input  logic [WIDTH-1:0] mask_din,
`endif
  output logic             grant_valid,
  output logic [IDX_W-1:0] grant_idx,
  output logic [WIDTH-1:0] grant_onehot,
  output logic             busy
);

  typedef enum logic [0:0] {StIdle, StGrant} state_e;

  state_e           state_q, state_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic [WIDTH-1:0] onehot_q, onehot_d;
  logic [IDX_W-1:0] ptr_q, ptr_d;
  logic [WIDTH-1:0] mask;
  logic [WIDTH-1:0] elig;

  logic             accept;
  logic [IDX_W-1:0] ptr_nxt;
  logic [IDX_W-1:0] ptr_eff;
  logic [IDX_W-1:0] fp_sel;
  logic [IDX_W-1:0] rr_sel;
  logic             rr_found;
  int               rr_j;
  logic [IDX_W-1:0] sel;
  logic [WIDTH-1:0] sel_onehot;

`ifdef PRIO_ARB_MASK_EN
  logic [WIDTH-1:0] mask_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mask_q <= '1;
    end else if (mask_we) begin
      mask_q <= mask_din;
    end
  end

  assign mask = mask_q;
`else
  assign mask = '1;
`endif

  assign elig = req & mask;

  // An accepted grant advances ptr; the re-arbitration on that same edge must
  // already search from the advanced pointer.
  assign accept  = (state_q == StGrant) && ack;
  assign ptr_nxt = (idx_q == IDX_W'(WIDTH - 1)) ? '0 : idx_q + 1'b1;
  assign ptr_eff = accept ? ptr_nxt : ptr_q;

  // Fixed priority: later (higher) indices overwrite earlier ones.
  always_comb begin
    fp_sel = '0;
    for (int i = 0; i < WIDTH; i++) begin
      if (elig[i]) begin
        fp_sel = IDX_W'(i);
      end
    end
  end

  // Round-robin: walk upward from ptr_eff with explicit wrap so WIDTH need not
  // be a power of two.
  always_comb begin
    rr_sel   = '0;
    rr_found = 1'b0;
    rr_j     = 0;
    for (int i = 0; i < WIDTH; i++) begin
      rr_j = int'(ptr_eff) + i;
      if (rr_j >= WIDTH) begin
        rr_j = rr_j - WIDTH;
      end
      if (!rr_found && elig[rr_j]) begin
        rr_found = 1'b1;
        rr_sel   = IDX_W'(rr_j);
      end
    end
  end

  assign sel = mode ? rr_sel : fp_sel;

  always_comb begin
    sel_onehot      = '0;
    sel_onehot[sel] = 1'b1;
  end

  always_comb begin
    state_d  = state_q;
    idx_d    = idx_q;
    onehot_d = onehot_q;
    ptr_d    = ptr_q;

    if (accept) begin
      ptr_d = ptr_nxt;
    end

    // Arbitrate when idle or when the held grant is being accepted.
    if ((state_q == StIdle) || accept) begin
      if (|elig) begin
        state_d  = StGrant;
        idx_d    = sel;
        onehot_d = sel_onehot;
      end else begin
        state_d  = StIdle;
        idx_d    = '0;
        onehot_d = '0;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= StIdle;
      idx_q    <= '0;
      onehot_q <= '0;
      ptr_q    <= '0;
    end else begin
      state_q  <= state_d;
      idx_q    <= idx_d;
      onehot_q <= onehot_d;
      ptr_q    <= ptr_d;
    end
  end

  assign grant_valid  = (state_q == StGrant);
  assign busy         = (state_q == StGrant);
  assign grant_idx    = idx_q;
  assign grant_onehot = onehot_q;

endmodule

// File: tb/tb_priority_arbiter.sv
// Scoreboard bench for priority_arbiter (WIDTH=8). Stimulus pushes the index
// each accepted grant must carry; the monitor pops on every grant_valid&&ack
// handshake at the falling edge. Inputs change 2 time units after rising edges.
module tb_priority_arbiter;

  localparam int W  = 8;
  localparam int IW = 3;

  logic          clk = 1'b0;
  logic          rst;
  logic [W-1:0]  req;
  logic          mode;
  logic          ack;
  logic          grant_valid;
  logic [IW-1:0] grant_idx;
  logic [W-1:0]  grant_onehot;
  logic          busy;
`ifdef PRIO_ARB_MASK_EN
  logic          mask_we;
  logic [W-1:0]  mask_din;
`endif

  int n_vec = 0;
  int n_err = 0;
  int exp_q[$];

  always #5 clk = ~clk;

  priority_arbiter #(
    .WIDTH (W),
    .IDX_W (IW)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .req          (req),
    .mode         (mode),
    .ack          (ack),
`ifdef PRIO_ARB_MASK_EN
    .mask_we      (mask_we),
    .mask_din     (mask_din),
`endif
    .grant_valid  (grant_valid),
    .grant_idx    (grant_idx),
    .grant_onehot (grant_onehot),
    .busy         (busy)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic chk_idle(input string name);
    chk({name, ".valid"}, 32'(grant_valid), 32'd0);
    chk({name, ".idx"}, 32'(grant_idx), 32'd0);
    chk({name, ".onehot"}, 32'(grant_onehot), 32'd0);
    chk({name, ".busy"}, 32'(busy), 32'd0);
  endtask

  task automatic chk_grant(input string name, input int idx);
    logic [W-1:0] oh;
    oh = W'(1) << idx;
    chk({name, ".valid"}, 32'(grant_valid), 32'd1);
    chk({name, ".idx"}, 32'(grant_idx), 32'(idx));
    chk({name, ".onehot"}, 32'(grant_onehot), 32'(oh));
  endtask

  // Monitor: each handshake consumes one expected grant index.
  always @(negedge clk) begin
    if (!rst && grant_valid && ack) begin
      if (exp_q.size() == 0) begin
        n_vec++;
        n_err++;
        $display("FAIL sb.unexpected: got grant %0d, expected none (t=%0t)", grant_idx, $time);
      end else begin
        int e;
        logic [W-1:0] oh;
        e  = exp_q.pop_front();
        oh = W'(1) << e;
        chk("sb.idx", 32'(grant_idx), 32'(e));
        chk("sb.onehot", 32'(grant_onehot), 32'(oh));
        chk("sb.busy", 32'(busy), 32'd1);
      end
    end
  end

  initial begin
    rst  = 1'b1;
    req  = '0;
    mode = 1'b0;
    ack  = 1'b0;
`ifdef PRIO_ARB_MASK_EN
    mask_we  = 1'b0;
    mask_din = '0;
`endif
    #3;
    chk_idle("reset");
    tick();
    tick();
    rst = 1'b0;

    // Empty request vector never grants.
    repeat (5) begin
      tick();
      chk("empty.valid", 32'(grant_valid), 32'd0);
    end

    // Fixed priority: 8'b0010_0110 -> 5 every time, valid one cycle after req.
    req = 8'b0010_0110;
    chk("fixed.latency0", 32'(grant_valid), 32'd0);
    tick();
    chk_grant("fixed.first", 5);
    repeat (4) exp_q.push_back(5);
    ack = 1'b1;
    repeat (4) tick();
    ack = 1'b0;
    chk_grant("fixed.again", 5);
    req = '0;
    exp_q.push_back(5);
    ack = 1'b1;
    tick();
    ack = 1'b0;
    chk_idle("fixed.drain");

    // Round-robin from reset with ack held: 0..7,0 with no bubble.
    rst = 1'b1;
    #1;
    chk_idle("rr.reset");
    mode = 1'b1;
    req  = 8'hFF;
    ack  = 1'b1;
    tick();
    rst = 1'b0;
    for (int i = 0; i < 9; i++) exp_q.push_back(i % 8);
    repeat (10) tick();
    ack = 1'b0;
    chk_grant("rr.after", 1);
    chk("rr.sb_drained", 32'(exp_q.size()), 32'd0);

    // Hold: get a grant on 3, drop req[3], ack low for 5 cycles.
    req = 8'h08;
    exp_q.push_back(1);
    ack = 1'b1;
    tick();
    ack = 1'b0;
    chk_grant("hold.start", 3);
    req = 8'h41;
    repeat (5) begin
      tick();
      chk_grant("hold.stable", 3);
    end
    // ptr 4 -> 6, then ptr 7 wraps to 0, then nothing eligible.
    exp_q.push_back(3);
    ack = 1'b1;
    tick();
    ack = 1'b0;
    chk_grant("hold.next", 6);
    exp_q.push_back(6);
    ack = 1'b1;
    tick();
    chk_grant("hold.wrap", 0);
    req = '0;
    exp_q.push_back(0);
    tick();
    ack = 1'b0;
    chk_idle("hold.idle");

    // Ack in idle is ignored.
    ack = 1'b1;
    repeat (2) tick();
    ack = 1'b0;
    chk_idle("idle.ack");

    // Edge: bring ptr to 7, request only 7 in round-robin, then ptr wraps to 0.
    mode = 1'b0;
    req  = 8'h40;
    tick();
    chk_grant("edge.six", 6);
    exp_q.push_back(6);
    exp_q.push_back(7);
    mode = 1'b1;
    req  = 8'h80;
    ack  = 1'b1;
    tick();
    chk_grant("edge.seven", 7);
    req = '0;
    tick();
    ack = 1'b0;
    chk_idle("edge.idle");
    req = 8'hFF;
    tick();
    chk_grant("edge.ptr0", 0);
    exp_q.push_back(0);
    ack = 1'b1;
    tick();
    ack = 1'b0;
    chk_grant("edge.next", 1);

    // Asynchronous reset mid-grant: outputs clear before the next edge.
    #1;
    rst = 1'b1;
    #1;
    chk_idle("rst.async");
    tick();
    chk_idle("rst.held");
    rst = 1'b0;
    tick();
    chk_grant("rst.ptr0", 0);
    req = '0;
    exp_q.push_back(0);
    ack = 1'b1;
    tick();
    ack = 1'b0;
    chk_idle("rst.drain");

`ifdef PRIO_ARB_MASK_EN
    // Mask 0x0F blocks req 0xF0; reopening grants the highest index.
    mode     = 1'b0;
    mask_we  = 1'b1;
    mask_din = 8'h0F;
    tick();
    mask_we = 1'b0;
    req     = 8'hF0;
    repeat (3) begin
      tick();
      chk("mask.blocked", 32'(grant_valid), 32'd0);
    end
    mask_we  = 1'b1;
    mask_din = 8'hFF;
    tick();
    mask_we = 1'b0;
    chk("mask.load_edge", 32'(grant_valid), 32'd0);
    tick();
    chk_grant("mask.open", 7);
    req = '0;
    exp_q.push_back(7);
    ack = 1'b1;
    tick();
    ack = 1'b0;
    chk_idle("mask.drain");
`endif

    repeat (2) tick();
    chk("sb.leftover", 32'(exp_q.size()), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/priority_arbiter.md
PRIORITY_ARBITER -- requirements
Module: priority_arbiter

Interface
REQ-001 Parameter WIDTH, default 32, number of request lines (WIDTH >= 2; need not be a power of two).
REQ-002 Parameter IDX_W, default $clog2(WIDTH), width of the grant index.
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 rst  input  1  reset; asynchronous, active-high.
REQ-005 req  input  WIDTH  request vector; bit n set = requester n pending.
REQ-006 mode  input  1  0 = fixed priority, 1 = round-robin.
REQ-007 ack  input  1  consumer accepts the current grant.
REQ-008 grant_valid  output  1  a grant is held.
REQ-009 grant_idx  output  IDX_W  index of the granted requester.
REQ-010 grant_onehot  output  WIDTH  one-hot form of grant_idx; all zero when grant_valid=0.
REQ-011 busy  output  1  high in state GRANT (equal to grant_valid).

Function
REQ-012 Two-state FSM: IDLE, GRANT; all outputs registered.
REQ-013 Eligible vector E = req AND mask (mask defined in Configuration).
REQ-014 IDLE: if E != 0, next edge -> GRANT with grant_idx = selected index; latency req-to-grant_valid exactly 1 cycle; if E == 0, remain IDLE.
REQ-015 Fixed priority (mode=0): the highest set index of E wins.
REQ-016 Round-robin (mode=1): search E from index ptr upward, wrapping WIDTH-1 -> 0; the first set bit wins.
REQ-017 ptr register, range 0..WIDTH-1; updated only on an accepted grant to (grant_idx+1) mod WIDTH; grant_idx = WIDTH-1 wraps ptr to 0; updated in both modes.
REQ-018 mode is sampled only on the arbitration edge; mid-grant changes have no effect on the held grant.
REQ-019 GRANT: grant_idx, grant_onehot, and grant_valid are held stable until ack=1, even if the granted req bit drops.
REQ-020 GRANT with ack=1: re-arbitrate on the same edge using the updated ptr; if E != 0, stay GRANT with the new index (back-to-back, no bubble); else -> IDLE with grant_valid=0 next cycle.
REQ-021 ack in IDLE is ignored.
REQ-022 Whenever grant_valid=0: grant_idx=0 and grant_onehot=0.

Reset
REQ-023 rst=1 forces IDLE, grant_valid=0, grant_idx=0, grant_onehot=0, busy=0, ptr=0 immediately, without waiting for clk.
REQ-024 rst asserted mid-grant discards the grant; ptr is not advanced.
REQ-025 The first arbitration occurs on the first rising edge after rst deasserts.

Configuration
REQ-026 Macro PRIO_ARB_MASK_EN defined: add ports mask_we (input, 1) and mask_din (input, WIDTH); mask register resets to all ones; mask_we=1 loads mask_din at the edge; the new mask applies to arbitrations after that edge; a held grant is unaffected.
REQ-027 Macro PRIO_ARB_MASK_EN undefined: mask_we and mask_din ports are absent; mask is constant all ones.

Verification (WIDTH=8 unless noted)
REQ-028 Fixed: mode=0, req=8'b0010_0110 held, ack pulses each grant -> grant_idx=5 repeatedly; grant_onehot=8'b0010_0000; grant_valid one cycle after req.
REQ-029 Round-robin: mode=1, req=8'hFF, ack=1 continuously after reset -> grants 0,1,...,7,0 on consecutive cycles, with no bubble.
REQ-030 Hold: grant to idx 3, drop req[3] with ack=0 for 5 cycles -> grant_idx stays 3, grant_valid=1; ack -> next eligible index or IDLE.
REQ-031 Reset mid-grant: assert rst asynchronously between edges while in GRANT -> outputs go to 0 before the next edge; ptr=0; after release with mode=1, req=8'hFF -> grant 0.
REQ-032 Empty/edge: req=0 -> grant_valid stays 0 indefinitely; req=8'h80 with mode=1 and ptr=7 -> grant 7, then ptr wraps to 0.
REQ-033 With PRIO_ARB_MASK_EN: write mask=8'h0F, req=8'hF0 -> no grant; write mask=8'hFF -> grant_idx=7 (mode=0).
